// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, mode codes, FSM states and helpers shared by the alu_seq block
package alu_pkg;
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MUL = 2'b01;
    localparam logic [1:0] MODE_MLA = 2'b10;

    typedef enum logic {S_IDLE, S_MULT} state_e;

    // TST/TEQ/CMP/CMN only produce flags, no writeback
    function automatic logic is_test(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: WIDTH+1-bit adder computing x + (inv_y ? ~y : y) + cin with carry and overflow
// Ports: x_i, y_i operands; inv_y_i inverts y for subtraction; cin_i carry-in;
//        sum_o result; c_o carry-out (NOT borrow when subtracting); v_o signed overflow
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             inv_y_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o,
    output logic             v_o
);
    logic [WIDTH-1:0] y_eff;
    assign y_eff = inv_y_i ? ~y_i : y_i;
    assign {c_o, sum_o} = {1'b0, x_i} + {1'b0, y_eff} + {{WIDTH{1'b0}}, cin_i};
    assign v_o = (x_i[WIDTH-1] == y_eff[WIDTH-1]) && (sum_o[WIDTH-1] != x_i[WIDTH-1]);
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ARM data-processing ALU with NZCV register and iterative MUL/MLA
// Ports: clk, rst (sync, active-high); in_valid/in_ready request handshake;
//        mode, alu_op, s_bit, a, b, acc, shift_cout operation inputs;
//        out_valid completion pulse; wr_en writeback enable; f result; nzcv flag register
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [3:0]       alu_op,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic             shift_cout,
    output logic             out_valid,
    output logic             wr_en,
    output logic [WIDTH-1:0] f,
    output logic [3:0]       nzcv
);
    state_e                 state_q, state_d;
    logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d, mplier_q, mplier_d, psum_q, psum_d, f_q, f_d;
    logic                   s_q, s_d, wr_en_q, wr_en_d, out_valid_q, out_valid_d;
    logic [3:0]             nzcv_q, nzcv_d;
    logic                   mult, swap, arith, is_mul, add_inv, add_cin, add_c, add_v;
    logic [WIDTH-1:0]       add_x, add_y, sum, logic_f, alu_f;

    assign mult   = state_q == S_MULT;
    assign is_mul = mode == MODE_MUL || mode == MODE_MLA;
    assign swap   = alu_op inside {OP_RSB, OP_RSC};
    assign arith  = alu_op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};

    // The single adder serves the ALU while idle and accumulates partial products while multiplying
    assign add_x   = mult ? psum_q : (swap ? b : a);
    assign add_y   = mult ? (mplier_q[0] ? mcand_q : '0) : (swap ? a : b);
    assign add_inv = !mult && (alu_op inside {OP_SUB, OP_RSB, OP_SBC, OP_RSC, OP_CMP});
    assign add_cin = !mult && ((alu_op inside {OP_ADC, OP_SBC, OP_RSC}) ? nzcv_q[1]
                                                                       : (alu_op inside {OP_SUB, OP_RSB, OP_CMP}));

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x_i    (add_x),
        .y_i    (add_y),
        .inv_y_i(add_inv),
        .cin_i  (add_cin),
        .sum_o  (sum),
        .c_o    (add_c),
        .v_o    (add_v)
    );

    always_comb begin
        logic_f = a & b;
        case (alu_op)
            OP_EOR, OP_TEQ: logic_f = a ^ b;
            OP_ORR:         logic_f = a | b;
            OP_MOV:         logic_f = b;
            OP_BIC:         logic_f = a & ~b;
            OP_MVN:         logic_f = ~b;
            default:        ;
        endcase
    end

    assign alu_f = arith ? sum : logic_f;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        psum_d      = psum_q;
        s_d         = s_q;
        f_d         = f_q;
        wr_en_d     = wr_en_q;
        nzcv_d      = nzcv_q;
        out_valid_d = 1'b0;
        if (mult) begin
            psum_d   = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + MUL_CNT_W'(1);
            if (cnt_q == MUL_CNT_W'(WIDTH - 1)) begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                f_d         = sum;
                wr_en_d     = 1'b1;
                out_valid_d = 1'b1;
                if (s_q) nzcv_d[3:2] = {sum[WIDTH-1], sum == '0};
            end
        end else if (in_valid) begin
            if (is_mul) begin
                state_d  = S_MULT;
                cnt_d    = '0;
                mcand_d  = a;
                mplier_d = b;
                psum_d   = (mode == MODE_MLA) ? acc : '0;
                s_d      = s_bit;
            end else begin
                f_d         = alu_f;
                wr_en_d     = !is_test(alu_op);
                out_valid_d = 1'b1;
                if (s_bit) nzcv_d = {alu_f[WIDTH-1], alu_f == '0, arith ? add_c : shift_cout,
                                     arith ? add_v : nzcv_q[0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            psum_q      <= '0;
            s_q         <= 1'b0;
            f_q         <= '0;
            wr_en_q     <= 1'b0;
            nzcv_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            psum_q      <= psum_d;
            s_q         <= s_d;
            f_q         <= f_d;
            wr_en_q     <= wr_en_d;
            nzcv_q      <= nzcv_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = !mult;
    assign out_valid = out_valid_q;
    assign wr_en     = wr_en_q;
    assign f         = f_q;
    assign nzcv      = nzcv_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the combinational data-processing ALU in the ARM execute stage. It implements all 16 ARM data-processing opcodes at WIDTH bits, and holds an internal NZCV flag register that is updated under an S bit. It also adds an iterative MUL/MLA unit behind a valid/ready handshake. It sits between the barrel shifter (operand B, shifter carry) and the writeback/CPSR logic.

## Interface
- WIDTH, 32, datapath width (≥ 4)
- MUL_CNT_W, $clog2(WIDTH), multiply iteration counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; low while multiplying
- mode  in  2  00 = ALU, 01 = MUL, 10 = MLA, 11 = reserved (treated as ALU)
- alu_op  in  4  ARM data-processing opcode (used when mode = ALU)
- s_bit  in  1  update flag register on completion
- a, b, acc  in  WIDTH each  Rn, shifted operand, MLA accumulator
- shift_cout  in  1  barrel-shifter carry-out
- out_valid  out  1  one-cycle pulse, result/flags valid
- wr_en  out  1  result is to be written back (0 for TST/TEQ/CMP/CMN)
- f  out  WIDTH  result
- nzcv  out  4  current flag register {N,Z,C,V}

## Operation
- Opcodes: 0 AND, 1 EOR, 2 SUB a−b, 3 RSB b−a, 4 ADD, 5 ADC a+b+C, 6 SBC a−b−!C, 7 RSC b−a−!C, 8 TST (AND), 9 TEQ (EOR), A CMP (SUB), B CMN (ADD), C ORR, D MOV b, E BIC a&~b, F MVN ~b.
- Carry-in for ADC/SBC/RSC is the internal flag register C, not an input.
- All add/sub operations use one WIDTH+1-bit adder: subtraction is x + ~y + cin.
  - C = adder carry-out; for subtraction this means C = NOT borrow.
  - V = (x[W−1] == y'[W−1]) && (f[W−1] != x[W−1]), where y' is the inverted operand for subtraction.
- Logical ops: C = shift_cout, V is unchanged.
- All ops: N = f[W−1], Z = (f == 0).
- MUL: f = (a·b) mod 2^W. MLA: f = (a·b + acc) mod 2^W.
  - Multiply sets N and Z; C and V are unchanged.
- Flags are written only when s_bit = 1 at completion. TST/TEQ/CMP/CMN update flags only if s_bit = 1.
- f is written for every op; wr_en marks whether writeback applies.
- FSM states:
  - IDLE: accept when in_valid. ALU mode completes next edge; MUL/MLA moves to MULT.
  - MULT: radix-2 shift-add. Latch multiplicand, multiplier and partial sum (partial sum = acc for MLA, 0 for MUL). One bit per cycle, counter 0..WIDTH−1. On the last bit, return to IDLE and pulse out_valid.
- in_valid while in_ready = 0 is ignored; the requester must hold the request.
- Reset values: state IDLE, in_ready 1, out_valid 0, wr_en 0, f 0, nzcv 0000, counter 0.

## Timing
- ALU op accepted at edge k: f, wr_en, nzcv and out_valid are registered at edge k+1 (latency 1). Back-to-back accepts are allowed every cycle.
- MUL/MLA accepted at edge k:
  - in_ready is low from edge k through edge k+WIDTH−1.
  - out_valid pulses after edge k+WIDTH.
  - in_ready is high again in that same cycle, so a new accept is possible at edge k+WIDTH+1.
- out_valid is high for exactly one cycle per accepted op. f and wr_en hold their value until the next completion.
- A flag update at edge k+1 is visible to an ADC accepted at edge k+1 (the carry used is the registered C).
- Reset mid-multiply: the partial product is discarded, the FSM returns to IDLE, and out_valid is not pulsed.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_AND … OP_MVN)
  - mode codes (MODE_ALU, MODE_MUL, MODE_MLA)
  - FSM state enum (S_IDLE, S_MULT)
  - an is_test(op) function (returns 1 for 8–B)
- Sub-module alu_addsub: combinational WIDTH+1 adder with operand-invert and carry-in controls, returning sum, C and V. It is instantiated once.

## Test plan
- ADD, s=1, a=0x7FFFFFFF, b=1: next cycle f=0x80000000, nzcv=1001, wr_en=1, out_valid for 1 cycle.
- CMP, s=1, a=5, b=5: f=0, wr_en=0, nzcv=0110. Then SUB, s=0, a=3, b=5: f=0xFFFFFFFE, nzcv stays 0110.
- ADD, s=1, 0xFFFFFFFF+1: C=1 (nzcv=0110). Next cycle ADC 1+1: f=3. Then SBC 5−2 with C=0 gives f=2.
- MUL 0x0000FFFF × 0x00010001, flags C=1, V=1 beforehand, s=1:
  - in_ready low for 32 cycles, out_valid after 32 edges
  - f=0xFFFFFFFF, nzcv=1011
  - in_valid pulses during busy are ignored
- MLA 3×4 + 0xFFFFFFF4: f=0, Z=1. Then TST, s=1, a=0xF0, b=0x0F, shift_cout=1: nzcv=0111, wr_en=0.
- rst asserted at cycle 10 of a MUL: next cycle in_ready=1, out_valid=0, nzcv=0000, f=0, and no out_valid ever appears for that multiply. Repeat with WIDTH=8: ADD 0x7F+1 gives f=0x80, nzcv=1001.
